// File: rtl/div_seq_ctrl.sv
// Sequential signed divider: non-restoring, one partial-remainder step per clock.
// Optional macro DIV_ZERO_TRAP_EN short-circuits divide-by-zero and raises dz.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz,
  output logic [2:0]       state_dbg
);

  // Handshake: start is a request taken only in S_IDLE; done is a one-cycle
  // valid strobe for hi/lo, and busy covers every cycle between accept and done.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_SIGN = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH:0]   a_r;
  logic [CW-1:0]    cnt;
  logic             qneg;
  logic             rneg;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  // Magnitudes are unsigned, so the most negative operand becomes 2^(WIDTH-1).
  always_comb begin
    m_ext   = {1'b0, m_r};
    a_sh    = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
    q_sh    = {q_r[WIDTH-2:0], 1'b0};
    a_step  = a_r[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    dvd_abs = dvd_r[WIDTH-1] ? (-dvd_r) : dvd_r;
    dvs_abs = dvs_r[WIDTH-1] ? (-dvs_r) : dvs_r;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      lo    <= '0;
      hi    <= '0;
      dvd_r <= '0;
      dvs_r <= '0;
      q_r   <= '0;
      m_r   <= '0;
      a_r   <= '0;
      cnt   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          qneg <= dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1];
          rneg <= dvd_r[WIDTH-1];
          a_r  <= '0;
          q_r  <= dvd_abs;
          m_r  <= dvs_abs;
          cnt  <= '0;
`ifdef DIV_ZERO_TRAP_EN
          if (dvs_r == '0) begin
            hi    <= dvd_r;
            lo    <= '1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_ITER;
          end
`else
          state <= S_ITER;
`endif
        end
        S_ITER: begin
          a_r <= a_step;
          q_r <= {q_sh[WIDTH-1:1], ~a_step[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= S_FIX;
        end
        S_FIX: begin
          // A negative final partial remainder is restored by one add.
          if (a_r[WIDTH]) a_r <= a_r + m_ext;
          state <= S_SIGN;
        end
        S_SIGN: begin
          lo    <= qneg ? (-q_r) : q_r;
          hi    <= rneg ? (-a_r[WIDTH-1:0]) : a_r[WIDTH-1:0];
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  // dz is sticky until the next operation reaches S_PREP.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dz <= 1'b0;
    end else if (state == S_PREP) begin
      dz <= (dvs_r == '0);
    end
  end
`else
  assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and random-model checks for div_seq_ctrl (WIDTH=32).
module tb_div_seq_ctrl;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        dz;
  logic [2:0]  state_dbg;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

`ifdef DIV_ZERO_TRAP_EN
  localparam int  DZ_LAT = 1;
  localparam logic DZ_EXP = 1'b1;
`else
  localparam int  DZ_LAT = 35;
  localparam logic DZ_EXP = 1'b0;
`endif

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .lo        (lo),
    .hi        (hi),
    .dz        (dz),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver + scoreboard for one division; inject pulses start mid-operation.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int exp_lat, input logic exp_dz, input bit inject);
    int          n;
    bit          got;
    logic [63:0] exp;
    exp_q.push_back({exp_lo, exp_hi});
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_acc"}, 64'(busy), 64'(1'b1));
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      if (inject && (n == 5 || n == 20)) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom | 32'h1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    exp   = exp_q.pop_front();
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    if (got) begin
      check({tag, "_lo"}, 64'(lo), 64'(exp[63:32]));
      check({tag, "_hi"}, 64'(hi), 64'(exp[31:0]));
      check({tag, "_dz"}, 64'(dz), 64'(exp_dz));
      check({tag, "_busy_done"}, 64'(busy), 64'(1'b1));
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 64'(done), 64'(1'b0));
      check({tag, "_busy_end"}, 64'(busy), 64'(1'b0));
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          sa;
    int          sb;
    clr      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_dz", 64'(dz), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    @(negedge clk);
    clr = 1'b1;

    run_div("p7_p2", 32'd7, 32'd2, 32'd3, 32'd1, 35, 1'b0, 1'b0);
    run_div("p7_n2", 32'd7, -32'd2, -32'd3, 32'd1, 35, 1'b0, 1'b0);
    run_div("n7_p2", -32'd7, 32'd2, -32'd3, -32'd1, 35, 1'b0, 1'b0);
    run_div("n7_n2", -32'd7, -32'd2, 32'd3, -32'd1, 35, 1'b0, 1'b0);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 35, 1'b0, 1'b0);
    run_div("max_1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 35, 1'b0, 1'b0);
    run_div("min_2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 35, 1'b0, 1'b0);
    run_div("n100_7", -32'd100, 32'd7, -32'd14, -32'd2, 35, 1'b0, 1'b0);
    run_div("p1000_n33", 32'd1000, -32'd33, -32'd30, 32'd10, 35, 1'b0, 1'b0);
    run_div("small_p", 32'd5, 32'd10, 32'd0, 32'd5, 35, 1'b0, 1'b0);
    run_div("small_n", -32'd5, 32'd10, 32'd0, -32'd5, 35, 1'b0, 1'b0);
    run_div("big_mag", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 35, 1'b0, 1'b0);
    run_div("ignore", 32'd12345, 32'd100, 32'd123, 32'd45, 35, 1'b0, 1'b1);
    run_div("div0", 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, DZ_LAT, DZ_EXP, 1'b0);

    // asynchronous reset in the middle of ITER
    @(negedge clk);
    dividend = 32'd999;
    divisor  = 32'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_lo", 64'(lo), 64'(0));
    check("mid_rst_hi", 64'(hi), 64'(0));
    check("mid_rst_state", 64'(state_dbg), 64'(0));
    @(negedge clk);
    clr = 1'b1;
    run_div("after_rst", 32'd999, 32'd4, 32'd249, 32'd3, 35, 1'b0, 1'b0);

    // random signed pairs against a truncating-division model
    for (int i = 0; i < 1000; i++) begin
      ra = (i % 2 == 0) ? $urandom : ($urandom_range(2000, 0) - 32'd1000);
      rb = (i % 3 == 0) ? $urandom : $urandom_range(40, 1);
      if ($urandom_range(1, 0) == 1) rb = -rb;
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
      sa = $signed(ra);
      sb = $signed(rb);
      run_div("rand", ra, rb, 32'(sa / sb), 32'(sa % sb), 35, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
